// File: rtl/sigmul_round_if.sv
// sigmul_round_if: upstream and downstream handshake plus data of the normalize/round stage
interface sigmul_round_if #(
    parameter int NSIG = 10,
    parameter int NEXP = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*NSIG+1:0]     p;
    logic [NEXP+1:0]       exp_in;
    logic                  sign_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [NSIG:0]         sig_out;
    logic [NEXP+1:0]       exp_out;
    logic                  sign_out;
    logic                  inexact;
    modport master (
        output in_valid, p, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, sig_out, exp_out, sign_out, inexact
    );
    modport slave (
        input  in_valid, p, exp_in, sign_in, out_ready,
        output in_ready, out_valid, sig_out, exp_out, sign_out, inexact
    );
endinterface

// File: rtl/sigmul_round.sv
// sigmul_round: two-stage normalize and round-to-nearest-even after the significand multiplier
module sigmul_round #(
    parameter int NSIG = 10,
    parameter int NEXP = 5
) (
    input logic          clk,
    input logic          rst,
    sigmul_round_if.slave bus
);
    localparam int EW = NEXP + 2;
    logic            s1_valid, s2_valid, s1_adv, s2_adv;
    logic            hi, n_g, n_s, s1_g, s1_s, s1_sign, inc;
    logic [NSIG-1:0] lo_sh;
    logic [NSIG:0]   n_keep, s1_keep, r_sig, o_sig;
    logic [NSIG+1:0] r;
    logic [EW-1:0]   n_e, s1_e, r_e, o_e;
    logic            o_sign, o_inexact;
    assign s2_adv        = !s2_valid || bus.out_ready;
    assign s1_adv        = !s1_valid || s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.sig_out   = o_sig;
    assign bus.exp_out   = o_e;
    assign bus.sign_out  = o_sign;
    assign bus.inexact   = o_inexact;
    // Normalize: take the window under the leading one, fold the tail into guard and sticky
    always_comb begin
        hi     = bus.p[2*NSIG+1];
        lo_sh  = bus.p[NSIG-1:0] << 1;
        n_keep = hi ? bus.p[2*NSIG+1:NSIG+1] : bus.p[2*NSIG:NSIG];
        n_g    = hi ? bus.p[NSIG] : bus.p[NSIG-1];
        n_s    = hi ? |bus.p[NSIG-1:0] : |lo_sh;
        n_e    = bus.exp_in + EW'(hi);
    end
    // Round to nearest even; an all-ones keep carries out and renormalizes to 1.0
    always_comb begin
        inc   = s1_g && (s1_s || s1_keep[0]);
        r     = {1'b0, s1_keep} + (NSIG+2)'(inc);
        r_sig = r[NSIG+1] ? {1'b1, {NSIG{1'b0}}} : r[NSIG:0];
        r_e   = s1_e + EW'(r[NSIG+1]);
    end
    // Stage registers: valids follow the advance chain, data loads only with a beat moving in
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_keep   <= '0;
            s1_g      <= 1'b0;
            s1_s      <= 1'b0;
            s1_e      <= '0;
            s1_sign   <= 1'b0;
            o_sig     <= '0;
            o_e       <= '0;
            o_sign    <= 1'b0;
            o_inexact <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= bus.in_valid;
            if (s1_adv && bus.in_valid) begin
                s1_keep <= n_keep;
                s1_g    <= n_g;
                s1_s    <= n_s;
                s1_e    <= n_e;
                s1_sign <= bus.sign_in;
            end
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                o_sig     <= r_sig;
                o_e       <= r_e;
                o_sign    <= s1_sign;
                o_inexact <= s1_g | s1_s;
            end
        end
    end
endmodule

// File: tb/tb_sigmul_round.sv
// tb_sigmul_round: table vectors through a scoreboard plus latency, backpressure and reset sequences
module tb_sigmul_round;
    typedef struct {
        logic [21:0] p;
        logic [6:0]  e;
        logic        sg;
        logic [10:0] xs;
        logic [6:0]  xe;
        logic        xi;
    } vec_t;

    logic clk, rst;
    int   tests, fails;
    vec_t tv [24];
    vec_t sb [$];
    vec_t mon_x;
    logic [19:0] hold;
    bit   done;

    sigmul_round_if #(.NSIG(10), .NEXP(5)) bus ();
    sigmul_round #(.NSIG(10), .NEXP(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [21:0] p, input logic [6:0] e, input logic sg);
        vec_t v;
        longint unsigned pv, keep, rem, half, sig;
        int sh;
        logic [6:0] ee;
        pv   = 64'(p);
        sh   = p[21] ? 11 : 10;
        keep = pv >> sh;
        rem  = pv & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        sig  = keep + (((rem > half) || (rem == half && keep[0])) ? 64'd1 : 64'd0);
        ee   = e + (p[21] ? 7'd1 : 7'd0);
        if (sig == 64'd2048) begin
            sig = 64'd1024;
            ee  = ee + 7'd1;
        end
        v.p = p; v.e = e; v.sg = sg;
        v.xs = sig[10:0]; v.xe = ee; v.xi = (rem != 64'd0);
        return v;
    endfunction

    // Drive one beat starting just after a rising edge; returns just after the accepting edge
    task automatic send(input vec_t v);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.p        = v.p;
        bus.exp_in   = v.e;
        bus.sign_in  = v.sg;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) sb.push_back(v);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every beat handed downstream must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got sig %h exp %h with no beat outstanding", bus.sig_out, bus.exp_out);
            end else begin
                mon_x = sb.pop_front();
                check("beat", 64'({bus.sig_out, bus.exp_out, bus.sign_out, bus.inexact}),
                      64'({mon_x.xs, mon_x.xe, mon_x.sg, mon_x.xi}));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clk = 0; rst = 1; tests = 0; fails = 0; done = 0;
        bus.in_valid = 0; bus.p = '0; bus.exp_in = '0; bus.sign_in = 0; bus.out_ready = 1;
        tv[0] = '{22'h100000, 7'h00, 1'b0, 11'h400, 7'h00, 1'b0};
        tv[1] = '{22'h240000, 7'h03, 1'b1, 11'h480, 7'h04, 1'b0};
        tv[2] = '{22'h3FFC00, 7'h00, 1'b0, 11'h400, 7'h02, 1'b1};
        tv[3] = '{22'h200400, 7'h00, 1'b1, 11'h400, 7'h01, 1'b1};
        tv[4] = '{22'h200C00, 7'h00, 1'b0, 11'h402, 7'h01, 1'b1};
        tv[5] = '{22'h000000, 7'h05, 1'b1, 11'h000, 7'h05, 1'b0};
        tv[6] = '{22'h1FFFFF, 7'h00, 1'b0, 11'h400, 7'h01, 1'b1};
        tv[7] = '{22'h200000, 7'h7F, 1'b0, 11'h400, 7'h00, 1'b0};
        tv[8] = '{22'h100001, 7'h10, 1'b1, 11'h400, 7'h10, 1'b1};
        tv[9] = '{22'h100600, 7'h7E, 1'b0, 11'h402, 7'h7E, 1'b1};
        for (int i = 10; i < 24; i++)
            tv[i] = model(22'($urandom), 7'($urandom), 1'($urandom));

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sig_out", 64'(bus.sig_out), 64'd0);
        check("rst_exp_out", 64'(bus.exp_out), 64'd0);
        check("rst_sign_out", 64'(bus.sign_out), 64'd0);
        check("rst_inexact", 64'(bus.inexact), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(tv[0]);
        @(negedge clk);
        check("lat_cycle1_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 1; i < 24; i++) send(tv[i]);
        drain();

        bus.out_ready = 0;
        send(tv[2]);
        send(tv[3]);
        fork
            begin
                send(tv[4]);
                send(tv[6]);
            end
            begin
                @(negedge clk);
                hold = {bus.sig_out, bus.exp_out, bus.sign_out, bus.inexact};
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold", 64'({bus.sig_out, bus.exp_out, bus.sign_out, bus.inexact}), 64'(hold));
                    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain();

        bus.out_ready = 0;
        send(tv[4]);
        send(tv[5]);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        sb.delete();
        @(negedge clk);
        check("rst_flight_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_flight_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.out_ready = 1;
        send(tv[9]);
        @(negedge clk);
        check("post_rst_lat1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("post_rst_lat2", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        fork
            begin
                for (int i = 0; i < 24; i++) send(tv[i]);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
